// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcodes, FSM encoding and single-cycle ALU function
// Contents:
//   OP_*       4-bit opcode map
//   state_t    handshake FSM states
//   alu_out_t  carry + MAXW-bit value returned by alu_single
//   alu_single result/carry for every op that completes in one cycle
package alu_seq_pkg;

    localparam int MAXW = 64;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_MAX  = 4'd5;
    localparam logic [3:0] OP_DIV  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_NAND = 4'd9;

    typedef enum logic [1:0] {IDLE, DIV_BUSY, DONE} state_t;

    typedef struct packed {
        logic            carry;
        logic [MAXW-1:0] value;
    } alu_out_t;

    // Operands arrive zero-extended from width bits; the value is masked back
    // to width bits. DIV and undefined opcodes yield zero with no carry.
    function automatic alu_out_t alu_single(input int width, input logic [3:0] op,
                                            input logic [MAXW-1:0] a, input logic [MAXW-1:0] b,
                                            input logic [7:0] sh);
        logic [MAXW:0]   sum;
        logic [MAXW-1:0] mask;
        alu_out_t        o;
        mask    = {MAXW{1'b1}} >> (MAXW - width);
        sum     = {1'b0, a} + {1'b0, b};
        o.carry = 1'b0;
        o.value = '0;
        case (op)
            OP_ADD:  begin
                o.value = sum[MAXW-1:0];
                // only bit 'width' of the sum can lie outside the mask
                o.carry = |(sum & ~{1'b0, mask});
            end
            OP_SUB:  begin
                o.value = a - b;
                o.carry = a < b;
            end
            OP_AND:  o.value = a & b;
            OP_OR:   o.value = a | b;
            OP_SLL:  o.value = a << sh;
            OP_MAX:  o.value = (a > b) ? a : b;
            OP_SLTU: o.value = {{(MAXW-1){1'b0}}, a < b};
            OP_SRL:  o.value = a >> sh;
            OP_NAND: o.value = ~(a & b);
            default: ;
        endcase
        o.value = o.value & mask;
        return o;
    endfunction

endpackage

// File: rtl/alu_seq_divider.sv
// alu_seq_divider: WIDTH-cycle restoring unsigned divider
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               load dividend/divisor and begin
//   dividend, divisor   operands, sampled only on start
//   busy                iterations in progress
//   done                one-cycle pulse when quotient is final
//   quotient            floor(dividend/divisor)
module alu_seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // quotient doubles as the dividend shift register: its MSB feeds the
    // partial remainder while the new quotient bit enters at the LSB
    assign shifted = {rem, quotient[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            quotient <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem      <= '0;
                dvs      <= divisor;
                quotient <= dividend;
                cnt      <= CW'(WIDTH);
                busy     <= 1'b1;
            end else if (busy) begin
                rem      <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                quotient <= {quotient[WIDTH-2:0], ~trial[WIDTH]};
                cnt      <= cnt - CW'(1);
                busy     <= cnt != CW'(1);
                done     <= cnt == CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq_param.sv
// alu_seq_param: handshaked parametrised ALU with registered result and flags
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid, in_ready    issue handshake
//   opcode                operation select (see alu_seq_pkg)
//   input1, input2        operands A and B
//   shiftValue            shift amount for SLL/SRL
//   out_valid, out_ready  writeback handshake
//   result                registered result
//   carryFlag             ADD carry / SUB borrow
//   zeroFlag              result == 0
module alu_seq_param
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [SHW-1:0]   shiftValue,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryFlag,
    output logic             zeroFlag
);

    state_t           state, state_nx;
    alu_out_t         alu;
    logic             accept, div_start, div_busy, div_done;
    logic [WIDTH-1:0] div_quo, res_nx;
    logic             carry_nx, unused_hi;

    assign accept    = in_valid && in_ready;
    // divide-by-zero skips the divider and completes like a single-cycle op
    assign div_start = accept && opcode == OP_DIV && input2 != '0;
    assign alu       = alu_single(WIDTH, opcode, MAXW'(input1), MAXW'(input2), 8'(shiftValue));
    assign unused_hi = ^alu.value;
    assign res_nx    = div_done ? div_quo : alu.value[WIDTH-1:0];
    assign carry_nx  = div_done ? 1'b0 : alu.carry;

    alu_seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (input1),
        .divisor  (input2),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = accept                           ? (div_start ? DIV_BUSY : DONE)
                 : (state == DIV_BUSY && div_done)  ? DONE
                 : (state == DONE && out_ready)     ? IDLE
                 : state;
    end

    always_comb begin
        in_ready  = (state == IDLE || (state == DONE && out_ready)) && !div_busy;
        out_valid = state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            carryFlag <= 1'b0;
            zeroFlag  <= 1'b0;
        end else if (div_done || (accept && !div_start)) begin
            result    <= res_nx;
            carryFlag <= carry_nx;
            zeroFlag  <= res_nx == '0;
        end
    end

endmodule

// File: tb/tb_alu_seq_param.sv
// tb_alu_seq_param: scoreboard bench with directed and randomized operations
module tb_alu_seq_param;

    localparam int W   = 16;
    localparam int SHW = $clog2(W);

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [3:0]     opcode = '0;
    logic [W-1:0]   input1 = '0;
    logic [W-1:0]   input2 = '0;
    logic [SHW-1:0] shiftValue = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   result;
    logic           carryFlag;
    logic           zeroFlag;

    int checks = 0;
    int passed = 0;
    bit rand_bp = 1'b0;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         z;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    alu_seq_param #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .input1     (input1),
        .input2     (input2),
        .shiftValue (shiftValue),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .carryFlag  (carryFlag),
        .zeroFlag   (zeroFlag)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: plain integer arithmetic on the operation definitions
    function automatic exp_t model(input int op, input longint a, input longint b, input int sh);
        longint m = longint'(1) << W;
        longint r = 0;
        bit     c = 1'b0;
        exp_t   e;
        case (op)
            0: begin r = a + b; c = r >= m; end
            1: begin r = a - b; c = a < b; end
            2: r = a & b;
            3: r = a | b;
            4: r = a << sh;
            5: r = (a > b) ? a : b;
            6: r = (b == 0) ? 0 : a / b;
            7: r = (a < b) ? 1 : 0;
            8: r = a >> sh;
            9: r = ~(a & b);
            default: r = 0;
        endcase
        r   = ((r % m) + m) % m;
        e.r = r[W-1:0];
        e.c = c;
        e.z = (r == 0);
        return e;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge
    task automatic issue(input int op, input int a, input int b, input int sh);
        int n = 0;
        in_valid   = 1'b1;
        opcode     = 4'(op);
        input1     = W'(a);
        input2     = W'(b);
        shiftValue = SHW'(sh);
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL issue_timeout: in_ready=0 after %0d cycles, required 1", n);
            in_valid = 1'b0;
            return;
        end
        sb.push_back(model(op, a, b, sh));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: result=%0h with no operation outstanding", result);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_result", 64'(result), 64'(mon_e.r));
                chk("sb_carry", 64'(carryFlag), 64'(mon_e.c));
                chk("sb_zero", 64'(zeroFlag), 64'(mon_e.z));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

    int t_op[5] = '{4, 8, 5, 9, 12};
    int t_a[5]  = '{'h0001, 'h8000, 'h1234, 'hFFFF, 'h0055};
    int t_b[5]  = '{'h0000, 'h0000, 'h1234, 'hFFFF, 'h00AA};
    int t_sh[5] = '{15, 15, 0, 0, 3};
    int t_r[5]  = '{'h8000, 'h0001, 'h1234, 'h0000, 'h0000};

    initial begin
        int n;
        bit busy_ready;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_result", 64'(result), 0);
        chk("rst_carry", 64'(carryFlag), 0);
        chk("rst_zero", 64'(zeroFlag), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 64'(in_ready), 1);

        issue(0, 'hFFFF, 'h0001, 0);
        chk("add_valid", 64'(out_valid), 1);
        chk("add_result", 64'(result), 0);
        chk("add_carry", 64'(carryFlag), 1);
        chk("add_zero", 64'(zeroFlag), 1);

        issue(1, 3, 5, 0);
        chk("sub_valid", 64'(out_valid), 1);
        chk("sub_result", 64'(result), 'hFFFE);
        chk("sub_carry", 64'(carryFlag), 1);
        chk("b2b_in_ready", 64'(in_ready), 1);
        issue(7, 3, 5, 0);
        chk("sltu_valid", 64'(out_valid), 1);
        chk("sltu_result", 64'(result), 1);

        issue(6, 1000, 7, 0);
        chk("div_in_ready0", 64'(in_ready), 0);
        n = 0;
        busy_ready = 1'b0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!out_valid && in_ready) busy_ready = 1'b1;
        end while (!out_valid && n < 100);
        chk("div_latency", 64'(n), W + 1);
        chk("div_busy_in_ready", 64'(busy_ready), 0);
        chk("div_result", 64'(result), 142);
        chk("div_carry", 64'(carryFlag), 0);

        issue(6, 5, 0, 0);
        chk("div0_valid", 64'(out_valid), 1);
        chk("div0_result", 64'(result), 0);
        chk("div0_zero", 64'(zeroFlag), 1);

        for (int i = 0; i < 5; i++) begin
            issue(t_op[i], t_a[i], t_b[i], t_sh[i]);
            chk("table_valid", 64'(out_valid), 1);
            chk("table_result", 64'(result), 64'(t_r[i]));
        end

        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(3, 'h00F0, 'h0F00, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_result", 64'(result), 'h0FF0);
            chk("bp_valid", 64'(out_valid), 1);
            chk("bp_in_ready", 64'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_drained", 64'(out_valid), 0);
        chk("bp_idle_ready", 64'(in_ready), 1);

        issue(6, 'hFFFF, 3, 0);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 64'(out_valid), 0);
        chk("abort_in_ready", 64'(in_ready), 1);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        issue(0, 2, 2, 0);
        chk("post_rst_valid", 64'(out_valid), 1);
        chk("post_rst_result", 64'(result), 4);

        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int op, a, b;
            op = $urandom_range(0, 15);
            a  = ($urandom_range(0, 7) == 0) ? 'hFFFF : $urandom_range(0, 'hFFFF);
            b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 'hFFFF);
            if (op == 6 && $urandom_range(0, 1) == 1) b = $urandom_range(0, 40);
            issue(op, a, b, $urandom_range(0, W - 1));
        end
        rand_bp = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
